// File: rtl/mem_rd_fifo.sv
// mem_rd_fifo: circular DEPTH x WIDTH sync FIFO exposing count and head entry
module mem_rd_fifo #(
    parameter int DEPTH = 3,
    parameter int WIDTH = 1,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [CW-1:0]    count,
    output logic [WIDTH-1:0] head
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rp, wp;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    assign head = mem[rp];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            rp    <= '0;
            wp    <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wp] <= din;
                wp      <= nxt(wp);
            end
            if (pop) rp <= nxt(rp);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && push) assert (count < CW'(DEPTH));
    end
endmodule

// File: rtl/mem_rd_stage.sv
// mem_rd_stage: read front end for the 2W1R register file with write forwarding
// and an output FIFO sized so an issued read always has a slot waiting for it.
module mem_rd_stage #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 1,
    parameter int OUT_DEPTH  = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_data,
    output logic [ADDR_WIDTH-1:0] mem_raddr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  snp_we0,
    input  logic [ADDR_WIDTH-1:0] snp_waddr0,
    input  logic [DATA_WIDTH-1:0] snp_wdata0,
    input  logic                  snp_we1,
    input  logic [ADDR_WIDTH-1:0] snp_waddr1,
    input  logic [DATA_WIDTH-1:0] snp_wdata1
);
    localparam int CW = $clog2(OUT_DEPTH + 1);

    logic                  s1_valid, s1_byp, accept, hit0, hit1;
    logic [DATA_WIDTH-1:0] s1_bdata;
    logic [CW-1:0]         count;

    assign mem_raddr  = req_addr;
    assign hit0       = snp_we0 && snp_waddr0 == req_addr;
    assign hit1       = snp_we1 && snp_waddr1 == req_addr;
    assign accept     = req_valid && req_ready;
    assign resp_valid = count != '0;
    // Reserve a slot for the read still in S1 so its push can never overflow
    assign req_ready  = ({1'b0, count} + (CW + 1)'(s1_valid)) < (CW + 1)'(OUT_DEPTH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_byp   <= 1'b0;
            s1_bdata <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_byp   <= hit0 || hit1;
                s1_bdata <= hit1 ? snp_wdata1 : snp_wdata0;
            end
        end
    end

    mem_rd_fifo #(.DEPTH(OUT_DEPTH), .WIDTH(DATA_WIDTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (s1_valid),
        .din   (s1_byp ? s1_bdata : mem_rdata),
        .pop   (resp_valid && resp_ready),
        .count (count),
        .head  (resp_data)
    );
endmodule

// File: tb/tb_mem_rd_stage.sv
// tb_mem_rd_stage: bench memory plus queue-based reference model of the read stage
module tb_mem_rd_stage;
    localparam int AW = 4;
    localparam int DW = 1;
    localparam int OD = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0, req_ready, resp_valid, resp_ready = 1'b1;
    logic [AW-1:0] req_addr = '0, mem_raddr, snp_waddr0 = '0, snp_waddr1 = '0;
    logic [DW-1:0] resp_data, mem_rdata, snp_wdata0 = '0, snp_wdata1 = '0;
    logic          snp_we0 = 1'b0, snp_we1 = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        logic [DW-1:0] d;
        int            avail;
    } ent_t;
    ent_t          q[$];
    logic [DW-1:0] gold [1 << AW];
    logic [DW-1:0] bmem [1 << AW];
    logic [DW-1:0] got[$];
    time           got_t[$];

    mem_rd_stage #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OUT_DEPTH(OD)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
        .snp_we0(snp_we0), .snp_waddr0(snp_waddr0), .snp_wdata0(snp_wdata0),
        .snp_we1(snp_we1), .snp_waddr1(snp_waddr1), .snp_wdata1(snp_wdata1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Memory: registered read of pre-write contents, port 1 wins on a collision
    always @(posedge clk) begin
        mem_rdata <= bmem[mem_raddr];
        if (snp_we0) bmem[snp_waddr0] <= snp_wdata0;
        if (snp_we1) bmem[snp_waddr1] <= snp_wdata1;
    end

    // Reference: a read returns the memory image after its issue cycle's writes,
    // becomes visible two cycles later, and at most OD reads are outstanding.
    always @(posedge clk) begin
        logic m_rdy, m_rv, acc, pop;
        ent_t e;
        if (!rst_n) q.delete();
        else begin
            m_rdy = q.size() < OD;
            m_rv  = q.size() > 0 && q[0].avail <= cyc;
            acc   = req_valid && m_rdy;
            pop   = m_rv && resp_ready;
            if (snp_we0) gold[snp_waddr0] = snp_wdata0;
            if (snp_we1) gold[snp_waddr1] = snp_wdata1;
            if (pop) void'(q.pop_front());
            if (acc) begin
                e.d     = gold[req_addr];
                e.avail = cyc + 2;
                q.push_back(e);
            end
        end
        cyc++;
    end

    always @(negedge rst_n) q.delete();

    always @(negedge clk) begin
        if (rst_n) begin
            chk("resp_valid", {31'b0, resp_valid}, {31'b0, q.size() > 0 && q[0].avail <= cyc});
            chk("req_ready", {31'b0, req_ready}, {31'b0, q.size() < OD});
            chk("mem_raddr", 32'(mem_raddr), 32'(req_addr));
            if (resp_valid && q.size() > 0) chk("resp_data", 32'(resp_data), 32'(q[0].d));
        end
    end

    always @(posedge clk) begin
        if (rst_n && resp_valid && resp_ready) begin
            got.push_back(resp_data);
            got_t.push_back($time);
        end
    end

    task automatic drv(input logic v, input int a, input logic e0, input int a0, input int d0,
                       input logic e1, input int a1, input int d1);
        @(negedge clk);
        req_valid  = v;
        req_addr   = AW'(a);
        snp_we0    = e0;
        snp_waddr0 = AW'(a0);
        snp_wdata0 = DW'(d0);
        snp_we1    = e1;
        snp_waddr1 = AW'(a1);
        snp_wdata1 = DW'(d1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drv(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic wr(input int a, input int d);
        drv(0, 0, 1, a, d, 0, 0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int a, first_stall, stall_n;
        logic [DW-1:0] pat [6];
        pat[0] = 1; pat[1] = 0; pat[2] = 1; pat[3] = 1; pat[4] = 0; pat[5] = 1;
        repeat (3) @(negedge clk);
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst_resp_data", 32'(resp_data), 32'd0);
        chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
        rst_n = 1'b1;
        for (int i = 0; i < (1 << AW); i++) wr(i, int'($urandom % 2));
        idle(2);

        // plain read with latency pin
        wr(5, 1);
        drv(1, 5, 0, 0, 0, 0, 0, 0);
        idle(1);
        chk("plain_early", {31'b0, resp_valid}, 32'd0);
        @(negedge clk);
        chk("plain_valid", {31'b0, resp_valid}, 32'd1);
        chk("plain_data", 32'(resp_data), 32'd1);
        idle(2);

        // read-during-write forwarding
        wr(3, 0);
        drv(1, 3, 1, 3, 1, 0, 0, 0);
        idle(1);
        @(negedge clk);
        chk("bypass_data", 32'(resp_data), 32'd1);
        idle(2);

        // dual write, port 1 wins, and memory keeps it
        drv(1, 7, 1, 7, 0, 1, 7, 1);
        idle(1);
        @(negedge clk);
        chk("dual_data", 32'(resp_data), 32'd1);
        idle(2);
        got.delete();
        drv(1, 7, 0, 0, 0, 0, 0, 0);
        idle(4);
        chk("dual_mem_n", got.size(), 1);
        if (got.size() == 1) chk("dual_mem", 32'(got[0]), 32'd1);

        // snapshot: a later write does not alter an issued read
        wr(2, 0);
        idle(1);
        got.delete();
        drv(1, 2, 0, 0, 0, 0, 0, 0);
        drv(0, 0, 1, 2, 1, 0, 0, 0);
        drv(1, 2, 0, 0, 0, 0, 0, 0);
        idle(5);
        chk("snap_n", got.size(), 2);
        if (got.size() == 2) begin
            chk("snap_old", 32'(got[0]), 32'd0);
            chk("snap_new", 32'(got[1]), 32'd1);
        end

        // backpressure
        for (int i = 0; i < 6; i++) wr(i, int'(pat[i]));
        idle(1);
        got.delete();
        got_t.delete();
        resp_ready = 1'b0;
        a = 0;
        first_stall = -1;
        stall_n = 0;
        for (int k = 0; k < 40 && a < 6; k++) begin
            drv(1, a, 0, 0, 0, 0, 0, 0);
            if (req_ready) a++;
            else begin
                if (first_stall < 0) first_stall = a;
                stall_n++;
                if (stall_n == 3) resp_ready = 1'b1;
            end
        end
        idle(10);
        chk("bp_accepts", a, 6);
        chk("bp_stall_at", first_stall, 3);
        chk("bp_n", got.size(), 6);
        if (got.size() == 6) begin
            for (int i = 0; i < 6; i++) chk($sformatf("bp_order%0d", i), 32'(got[i]), 32'(pat[i]));
            chk("bp_rate", 32'(got_t[5] - got_t[0]), 32'd50);
        end

        // async reset with 2 queued and 1 in S1
        got.delete();
        resp_ready = 1'b0;
        drv(1, 1, 0, 0, 0, 0, 0, 0);
        drv(1, 2, 0, 0, 0, 0, 0, 0);
        drv(1, 3, 0, 0, 0, 0, 0, 0);
        idle(1);
        chk("rst_pre_valid", {31'b0, resp_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst_async_ready", {31'b0, req_ready}, 32'd1);
        idle(2);
        rst_n = 1'b1;
        resp_ready = 1'b1;
        @(negedge clk);
        chk("rst_rel_ready", {31'b0, req_ready}, 32'd1);
        idle(6);
        chk("rst_stale", got.size(), 0);

        // randomized traffic
        for (int k = 0; k < 800; k++) begin
            int ra;
            ra = int'($urandom % (1 << AW));
            drv(($urandom % 4) != 0, ra,
                ($urandom % 3) == 0, ($urandom % 2) ? ra : int'($urandom % (1 << AW)), int'($urandom % 2),
                ($urandom % 3) == 0, ($urandom % 2) ? ra : int'($urandom % (1 << AW)), int'($urandom % 2));
            resp_ready = (k % 64) < 40 ? ($urandom % 4) != 0 : ($urandom % 5) == 0;
        end
        resp_ready = 1'b1;
        idle(10);
        chk("drain_empty", {31'b0, resp_valid}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
